if_fetch_queue: RTL

- Instruction fetch front end between the program counter and the IF/ID pipeline register.
- Drives the synchronous instruction SRAM, which has 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to IF/ID.
- Absorbs hazard-unit stalls without losing in-flight reads; flushes on a branch redirect.

---
 rtl/if_fetch_queue.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end between the program counter
// and the IF/ID register. Issues reads to a 1-cycle-latency instruction SRAM,
// buffers {word, pc} pairs in a DEPTH-entry FIFO and presents the head to ID.
// A credit rule (count + inflight - pop < DEPTH) keeps a returning word from
// ever landing on a full FIFO. Redirects flush the queue and drop any read in
// flight. A misaligned redirect parks the fetcher in HALT with fetch_fault set.
// Optional build macro IF_FETCH_QUEUE_BYPASS_EN: when the FIFO is empty, a
// returning word is presented combinationally in the cycle it arrives.
module if_fetch_queue #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 11,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [WIDTH-1:0]  imem_rdata,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_pc,
  input  logic              stall,
  output logic              inst_valid,
  output logic [WIDTH-1:0]  inst_out,
  output logic [WIDTH-1:0]  inst_pc,
  output logic              fetch_fault
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_fetch_pc;
  logic               r_inflight;
  logic [WIDTH-1:0]   r_tag;

  logic [WIDTH-1:0]   r_mem_data [DEPTH];
  logic [WIDTH-1:0]   r_mem_pc   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_fifo_empty;
  logic               w_head_valid;
  logic [WIDTH-1:0]   w_head_data;
  logic [WIDTH-1:0]   w_head_pc;
  logic               w_out_valid;
  logic               w_pop;
  logic               w_pop_fifo;
  logic               w_push;
  logic               w_aligned;
  logic [SUM_W-1:0]   w_used;
  logic               w_credit;

  assign w_fifo_empty = (r_count == '0);
  assign w_aligned    = (redirect_pc[1:0] == 2'b00);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
  // Empty FIFO with a word arriving: show the SRAM output directly.
  logic w_bypass;
  assign w_bypass     = w_fifo_empty & r_inflight;
  assign w_head_valid = ~w_fifo_empty | r_inflight;
  assign w_head_data  = w_fifo_empty ? imem_rdata : r_mem_data[r_rd_ptr];
  assign w_head_pc    = w_fifo_empty ? r_tag      : r_mem_pc[r_rd_ptr];
  // A bypassed word consumed this cycle never enters the FIFO.
  assign w_push       = r_inflight & ~redirect_valid & ~(w_bypass & w_pop);
`else
  assign w_head_valid = ~w_fifo_empty;
  assign w_head_data  = r_mem_data[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_push       = r_inflight & ~redirect_valid;
`endif

  assign w_out_valid = (r_state == S_RUN) & w_head_valid;
  assign w_pop       = w_out_valid & ~stall;
  assign w_pop_fifo  = w_pop & ~w_fifo_empty;

  // Credit: entries held plus the read in flight, less what leaves this cycle.
  assign w_used   = SUM_W'(r_count) + SUM_W'(r_inflight);
  assign w_credit = (w_used < (SUM_W'(DEPTH) + SUM_W'(w_pop)));

  assign inst_valid  = w_out_valid;
  assign inst_out    = w_out_valid ? w_head_data : '0;
  assign inst_pc     = w_out_valid ? w_head_pc   : '0;
  assign fetch_fault = (r_state == S_HALT);
  assign imem_addr   = r_fetch_pc[ADDR_W+1:2];

  // Next-state and read-strobe decode.
  // NOTE: every output of this block is given a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        imem_req = ~rst & ~redirect_valid & w_credit;
        if (redirect_valid && !w_aligned) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        if (redirect_valid && w_aligned) w_state_nxt = S_RUN;
      end
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_nxt;
  end

  // Fetch PC, in-flight flag and the PC tag of the outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_req;
      if (imem_req) begin
        r_tag      <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop_fifo);
    end
  end

  // FIFO storage writes.
  // NOTE: the storage array has no reset; occupancy and pointers decide
  // what is valid, so clearing the words would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_tag;
    end
  end

endmodule
